// File: rtl/pipe_pkg.sv
// Shared constants and the per-stage action decode for the pipeline register chain.
package pipe_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_CNT_W = 16;
  localparam logic [DEF_CNT_W-1:0] DEF_CNT_MAX = '1;

  typedef enum logic [1:0] {
    ACT_LOAD,
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_FLUSH
  } stage_act_t;

  // Flush beats hold, hold beats bubble, bubble beats load.
  function automatic stage_act_t stage_action(input logic flush, input logic hold,
                                              input logic bubble);
    if (flush)       return ACT_FLUSH;
    else if (hold)   return ACT_HOLD;
    else if (bubble) return ACT_BUBBLE;
    else             return ACT_LOAD;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register: valid bit plus payload with flush/hold/bubble/load select.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             hold,
  input  logic             bubble,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      unique case (stage_action(flush, hold, bubble))
        ACT_FLUSH, ACT_BUBBLE: begin
          valid <= 1'b0;
          data  <= '0;
        end
        ACT_HOLD: begin
          valid <= valid;
          data  <= data;
        end
        default: begin
          valid <= load_valid;
          data  <= load_data;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH-stage pipeline register chain with per-stage stall/flush and stall/flush cycle counters.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  input  logic [WIDTH-1:0] InData,
  output logic             InReady,
  input  logic [DEPTH-1:0] StallVec,
  input  logic [DEPTH-1:0] FlushVec,
  input  logic             ClearCounters,
  output logic             OutValid,
  output logic [WIDTH-1:0] OutData,
  output logic [DEPTH-1:0] StageValid,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DEPTH-1:0] hold;
  logic [WIDTH-1:0] stage_data [DEPTH];

  genvar k;
  generate
    for (k = 0; k < DEPTH; k++) begin : g_stage
      // A stall anywhere downstream freezes this stage too.
      assign hold[k] = |StallVec[DEPTH-1:k];

      if (k == 0) begin : g_first
        pipe_stage_reg #(.WIDTH(WIDTH)) u_reg (
          .clk        (Clock),
          .rst        (Reset),
          .flush      (FlushVec[0]),
          .hold       (hold[0]),
          .bubble     (1'b0),
          .load_valid (InValid & InReady),
          .load_data  (InValid ? InData : '0),
          .valid      (StageValid[0]),
          .data       (stage_data[0])
        );
      end else begin : g_next
        pipe_stage_reg #(.WIDTH(WIDTH)) u_reg (
          .clk        (Clock),
          .rst        (Reset),
          .flush      (FlushVec[k]),
          .hold       (hold[k]),
          .bubble     (hold[k-1]),
          .load_valid (StageValid[k-1]),
          .load_data  (stage_data[k-1]),
          .valid      (StageValid[k]),
          .data       (stage_data[k])
        );
      end
    end
  endgenerate

  assign InReady  = ~hold[0];
  assign OutValid = StageValid[DEPTH-1];
  assign OutData  = stage_data[DEPTH-1];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      StallCycles <= '0;
      FlushCycles <= '0;
    end else if (ClearCounters) begin
      StallCycles <= '0;
      FlushCycles <= '0;
    end else begin
      if (|StallVec && StallCycles != CNT_MAX) StallCycles <= StallCycles + CNT_W'(1);
      if (|FlushVec && FlushCycles != CNT_MAX) FlushCycles <= FlushCycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain at WIDTH=32, DEPTH=4, CNT_W=16.
module tb_pipe_stage_chain;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        InValid = 1'b0;
  logic [31:0] InData = '0;
  logic        InReady;
  logic [3:0]  StallVec = '0;
  logic [3:0]  FlushVec = '0;
  logic        ClearCounters = 1'b0;
  logic        OutValid;
  logic [31:0] OutData;
  logic [3:0]  StageValid;
  logic [15:0] StallCycles;
  logic [15:0] FlushCycles;

  int checks = 0;
  int failures = 0;

  pipe_stage_chain #(.WIDTH(32), .DEPTH(4), .CNT_W(16)) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .InValid       (InValid),
    .InData        (InData),
    .InReady       (InReady),
    .StallVec      (StallVec),
    .FlushVec      (FlushVec),
    .ClearCounters (ClearCounters),
    .OutValid      (OutValid),
    .OutData       (OutData),
    .StageValid    (StageValid),
    .StallCycles   (StallCycles),
    .FlushCycles   (FlushCycles)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic [3:0]  st;
    logic [3:0]  fl;
    logic        clr;
    logic        rdy;
    logic        ov;
    logic [31:0] od;
    logic [3:0]  sv;
    logic [15:0] sc;
    logic [15:0] fc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic iv, input logic [31:0] id, input logic [3:0] st,
                     input logic [3:0] fl, input logic clr, input logic rdy, input logic ov,
                     input logic [31:0] od, input logic [3:0] sv, input logic [15:0] sc,
                     input logic [15:0] fc);
    vec_t v;
    v.iv = iv; v.id = id; v.st = st; v.fl = fl; v.clr = clr;
    v.rdy = rdy; v.ov = ov; v.od = od; v.sv = sv; v.sc = sc; v.fc = fc;
    vecs.push_back(v);
  endtask

  task automatic cyc(input logic iv, input logic [31:0] id, input logic [3:0] st,
                     input logic [3:0] fl, input logic clr);
    @(negedge Clock);
    InValid = iv; InData = id; StallVec = st; FlushVec = fl; ClearCounters = clr;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    // stream of three, no stall
    add(1, 32'h11, 0, 0, 0, 1, 0, 32'h00, 4'b0001, 0, 0);
    add(1, 32'h22, 0, 0, 0, 1, 0, 32'h00, 4'b0011, 0, 0);
    add(1, 32'h33, 0, 0, 0, 1, 0, 32'h00, 4'b0111, 0, 0);
    add(0, 32'h00, 0, 0, 0, 1, 1, 32'h11, 4'b1110, 0, 0);
    add(0, 32'h00, 0, 0, 0, 1, 1, 32'h22, 4'b1100, 0, 0);
    add(0, 32'h00, 0, 0, 0, 1, 1, 32'h33, 4'b1000, 0, 0);
    add(0, 32'h00, 0, 0, 0, 1, 0, 32'h00, 4'b0000, 0, 0);
    // fill, then stall stage 2 for two cycles with 0x45 waiting
    add(1, 32'h41, 0, 0, 0, 1, 0, 32'h00, 4'b0001, 0, 0);
    add(1, 32'h42, 0, 0, 0, 1, 0, 32'h00, 4'b0011, 0, 0);
    add(1, 32'h43, 0, 0, 0, 1, 0, 32'h00, 4'b0111, 0, 0);
    add(1, 32'h44, 0, 0, 0, 1, 1, 32'h41, 4'b1111, 0, 0);
    add(1, 32'h45, 4'b0100, 0, 0, 0, 0, 32'h00, 4'b0111, 1, 0);
    add(1, 32'h45, 4'b0100, 0, 0, 0, 0, 32'h00, 4'b0111, 2, 0);
    add(1, 32'h45, 0, 0, 0, 1, 1, 32'h42, 4'b1111, 2, 0);
    add(0, 32'h00, 0, 0, 0, 1, 1, 32'h43, 4'b1110, 2, 0);
    add(0, 32'h00, 0, 0, 0, 1, 1, 32'h44, 4'b1100, 2, 0);
    add(0, 32'h00, 0, 0, 0, 1, 1, 32'h45, 4'b1000, 2, 0);
    add(0, 32'h00, 0, 0, 0, 1, 0, 32'h00, 4'b0000, 2, 0);
    // fill, then flush stages 0-1 while stage 0 stalls
    add(1, 32'h51,       0, 0, 0, 1, 0, 32'h00, 4'b0001, 2, 0);
    add(1, 32'h52,       0, 0, 0, 1, 0, 32'h00, 4'b0011, 2, 0);
    add(1, 32'hCAFE0053, 0, 0, 0, 1, 0, 32'h00, 4'b0111, 2, 0);
    add(1, 32'h54,       0, 0, 0, 1, 1, 32'h51, 4'b1111, 2, 0);
    add(1, 32'h55, 4'b0001, 4'b0011, 0, 0, 1, 32'h52, 4'b1100, 3, 1);
    add(0, 32'h00, 0, 0, 0, 1, 1, 32'hCAFE0053, 4'b1000, 3, 1);
    add(0, 32'h00, 0, 0, 0, 1, 0, 32'h00, 4'b0000, 3, 1);
    // clear overrides both increments
    add(0, 32'h00, 4'b0010, 4'b0100, 1, 0, 0, 32'h00, 4'b0000, 0, 0);

    #2 Reset = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    chk("rst_stage_valid", 64'(StageValid), 64'h0);
    chk("rst_out_valid", 64'(OutValid), 64'h0);
    chk("rst_out_data", 64'(OutData), 64'h0);
    chk("rst_stall_cnt", 64'(StallCycles), 64'h0);
    chk("rst_flush_cnt", 64'(FlushCycles), 64'h0);
    chk("rst_in_ready", 64'(InReady), 64'h1);
    Reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge Clock);
      InValid = vecs[i].iv; InData = vecs[i].id; StallVec = vecs[i].st;
      FlushVec = vecs[i].fl; ClearCounters = vecs[i].clr;
      #1;
      chk($sformatf("v%0d_in_ready", i), 64'(InReady), 64'(vecs[i].rdy));
      @(posedge Clock);
      #1;
      chk($sformatf("v%0d_out_valid", i), 64'(OutValid), 64'(vecs[i].ov));
      chk($sformatf("v%0d_out_data", i), 64'(OutData), 64'(vecs[i].od));
      chk($sformatf("v%0d_stage_valid", i), 64'(StageValid), 64'(vecs[i].sv));
      chk($sformatf("v%0d_stall_cnt", i), 64'(StallCycles), 64'(vecs[i].sc));
      chk($sformatf("v%0d_flush_cnt", i), 64'(FlushCycles), 64'(vecs[i].fc));
    end

    // stall counter saturation
    for (int i = 0; i < 65534; i++) cyc(0, 0, 4'b0001, 0, 0);
    chk("sat_stall_fffe", 64'(StallCycles), 64'hFFFE);
    cyc(0, 0, 4'b0001, 0, 0);
    chk("sat_stall_ffff", 64'(StallCycles), 64'hFFFF);
    for (int i = 0; i < 5; i++) cyc(0, 0, 4'b0001, 0, 0);
    chk("sat_stall_hold", 64'(StallCycles), 64'hFFFF);
    chk("sat_flush_zero", 64'(FlushCycles), 64'h0);
    cyc(0, 0, 4'b0001, 0, 1);
    chk("sat_clear", 64'(StallCycles), 64'h0);
    cyc(0, 0, 0, 0, 0);
    chk("sat_after_clear", 64'(StallCycles), 64'h0);

    // async reset with a full chain
    cyc(0, 0, 4'b1000, 0, 0);
    chk("pre_rst_stall_cnt", 64'(StallCycles), 64'h1);
    cyc(1, 32'h61, 0, 0, 0);
    cyc(1, 32'h62, 0, 0, 0);
    cyc(1, 32'h63, 0, 0, 0);
    cyc(1, 32'h64, 0, 0, 0);
    chk("pre_rst_full", 64'(StageValid), 64'hF);
    chk("pre_rst_out", 64'(OutData), 64'h61);
    @(negedge Clock);
    InValid = 1'b0;
    #2 Reset = 1'b1;
    #1;
    chk("arst_stage_valid", 64'(StageValid), 64'h0);
    chk("arst_out_data", 64'(OutData), 64'h0);
    chk("arst_out_valid", 64'(OutValid), 64'h0);
    chk("arst_stall_cnt", 64'(StallCycles), 64'h0);
    StallVec = 4'b0001;
    #1 chk("arst_ready_stalled", 64'(InReady), 64'h0);
    StallVec = 4'b0000;
    #1 chk("arst_ready_free", 64'(InReady), 64'h1);
    InValid = 1'b1; InData = 32'h99;
    @(posedge Clock);
    #1 chk("arst_no_capture", 64'(StageValid), 64'h0);
    @(negedge Clock);
    Reset = 1'b0;
    InData = 32'hAA;
    @(posedge Clock);
    #1 chk("post_rst_capture", 64'(StageValid), 64'h1);
    chk("post_rst_e1_out", 64'(OutValid), 64'h0);
    @(negedge Clock);
    InValid = 1'b0; InData = 32'h0;
    @(posedge Clock);
    #1 chk("post_rst_e2_out", 64'(OutValid), 64'h0);
    @(posedge Clock);
    #1 chk("post_rst_e3_out", 64'(OutValid), 64'h0);
    @(posedge Clock);
    #1 chk("post_rst_e4_valid", 64'(OutValid), 64'h1);
    chk("post_rst_e4_data", 64'(OutData), 64'hAA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
